sd_dat_tx_ctrl: RTL and testbench

SD_DAT_TX_CTRL -- requirements
Module: sd_dat_tx_ctrl

---
 rtl/sd_dat_tx_ctrl.sv | 147 ++++++++++++++
 tb/tb_sd_dat_tx_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_tx_ctrl.sv
// rtl/sd_dat_tx_ctrl.sv - SD 1-bit DAT write frame sequencer: start bit, BLKSIZE bytes, CRC16, end bit.
// Define SD_DAT_TX_ABORT_EN to add the ABORT input.
module sd_dat_tx_ctrl #(
    parameter int BLKSIZE = 512
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        START,
`ifdef SD_DAT_TX_ABORT_EN
    input  logic        ABORT,
`endif
    input  logic [7:0]  DIN,
    input  logic        DIN_VALID,
    output logic        DIN_READY,
    output logic        DAT_OUT,
    output logic        DAT_OE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] CRC
);
    localparam int            CW        = 15;
    localparam logic [CW-1:0] LAST_DATA = CW'(8 * BLKSIZE - 1);
    localparam logic [CW-1:0] LAST_CRC  = CW'(15);

    typedef enum logic [2:0] {IDLE, STRT, DATA, CRCO, ENDB} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   sh;
    logic [7:0]    buf_q;
    logic          buf_full;
    logic          xfer;
    logic          have_byte;
    logic [7:0]    next_byte;
    logic          abort_req;
    logic          inv;
    logic [15:0]   crc_next;

    assign DIN_READY = !buf_full && (state == STRT || state == DATA);
    assign BUSY      = (state != IDLE);
    // The line is always the shift register MSB; non-data states load constants into it.
    assign DAT_OUT   = sh[15];
    assign xfer      = DIN_VALID && DIN_READY;
    // A byte arriving while the buffer is empty goes straight to the shifter at a move.
    assign have_byte = buf_full || xfer;
    assign next_byte = buf_full ? buf_q : DIN;
    assign inv       = sh[15] ^ CRC[15];
    assign crc_next  = {CRC[14:0], 1'b0} ^ ({16{inv}} & 16'h1021);

`ifdef SD_DAT_TX_ABORT_EN
    assign abort_req = ABORT && (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '1;
            buf_q    <= '0;
            buf_full <= 1'b0;
            DAT_OE   <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            CRC      <= '0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            if (xfer) begin
                buf_q    <= DIN;
                buf_full <= 1'b1;
            end
            if (abort_req) begin
                state  <= IDLE;
                sh     <= '1;
                DAT_OE <= 1'b0;
                ERR    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (START) begin
                            state    <= STRT;
                            CRC      <= '0;
                            buf_full <= 1'b0;
                            cnt      <= '0;
                            sh       <= '0;
                            DAT_OE   <= 1'b1;
                        end
                    end
                    STRT: begin
                        if (have_byte) begin
                            state    <= DATA;
                            sh       <= {next_byte, 8'hFF};
                            buf_full <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            sh     <= '1;
                            DAT_OE <= 1'b0;
                            ERR    <= 1'b1;
                        end
                    end
                    DATA: begin
                        CRC <= crc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_DATA) begin
                            state <= CRCO;
                            cnt   <= '0;
                            sh    <= crc_next;
                        end else if (cnt[2:0] == 3'd7) begin
                            if (have_byte) begin
                                sh       <= {next_byte, 8'hFF};
                                buf_full <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                sh     <= '1;
                                DAT_OE <= 1'b0;
                                ERR    <= 1'b1;
                            end
                        end else begin
                            sh <= {sh[14:0], 1'b1};
                        end
                    end
                    CRCO: begin
                        cnt <= cnt + 1'b1;
                        sh  <= {sh[14:0], 1'b1};
                        if (cnt == LAST_CRC) begin
                            state <= ENDB;
                            sh    <= '1;
                            DONE  <= 1'b1;
                        end
                    end
                    ENDB: begin
                        state  <= IDLE;
                        DAT_OE <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        sh     <= '1;
                        DAT_OE <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_dat_tx_ctrl.sv
// tb/tb_sd_dat_tx_ctrl.sv - directed bench for sd_dat_tx_ctrl (BLKSIZE 512 and 4 instances).
// Define SD_DAT_TX_ABORT_EN to also exercise ABORT.
module tb_sd_dat_tx_ctrl;
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        b_rst_n, b_start, b_valid, b_rdy, b_dat, b_oe, b_busy, b_done, b_err;
    logic [7:0]  b_din;
    logic [15:0] b_crc;
    logic        s_rst_n, s_start, s_valid, s_rdy, s_dat, s_oe, s_busy, s_done, s_err;
    logic [7:0]  s_din;
    logic [15:0] s_crc;
`ifdef SD_DAT_TX_ABORT_EN
    logic b_abort, s_abort;
`endif

    sd_dat_tx_ctrl #(.BLKSIZE(512)) u_big (
        .CLK(clk), .RST_n(b_rst_n), .START(b_start),
`ifdef SD_DAT_TX_ABORT_EN
        .ABORT(b_abort),
`endif
        .DIN(b_din), .DIN_VALID(b_valid), .DIN_READY(b_rdy), .DAT_OUT(b_dat),
        .DAT_OE(b_oe), .BUSY(b_busy), .DONE(b_done), .ERR(b_err), .CRC(b_crc)
    );

    sd_dat_tx_ctrl #(.BLKSIZE(4)) u_small (
        .CLK(clk), .RST_n(s_rst_n), .START(s_start),
`ifdef SD_DAT_TX_ABORT_EN
        .ABORT(s_abort),
`endif
        .DIN(s_din), .DIN_VALID(s_valid), .DIN_READY(s_rdy), .DAT_OUT(s_dat),
        .DAT_OE(s_oe), .BUSY(s_busy), .DONE(s_done), .ERR(s_err), .CRC(s_crc)
    );

    typedef struct {
        logic        start;
        logic [7:0]  din;
        logic        valid;
        logic [21:0] exp;
    } vec_t;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nmis++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    function automatic vec_t mk(input logic st, input logic [7:0] d, input logic v,
                                input logic edat, input logic eoe, input logic erdy,
                                input logic ebusy, input logic edone, input logic eerr,
                                input logic [15:0] ecrc);
        vec_t r;
        r.start = st;
        r.din   = d;
        r.valid = v;
        r.exp   = {edat, eoe, erdy, ebusy, edone, eerr, ecrc};
        return r;
    endfunction

    task automatic run_big(input logic [7:0] v, input logic [15:0] ecrc, input string tag);
        int          ones   = 0;
        int          dones  = 0;
        logic [15:0] crcbits = '0;
        logic [15:0] crc_at = '0;
        logic        sbit   = 1'b1;
        logic        ebit   = 1'b0;
        logic        done_at = 1'b0;
        logic        busy_after = 1'b1;
        for (int c = 0; c < 4120; c++) begin
            @(negedge clk);
            if (c == 1) sbit = b_dat;
            if (c >= 2 && c <= 4097) ones += int'(b_dat);
            if (c == 4098) crc_at = b_crc;
            if (c >= 4098 && c <= 4113) crcbits = {crcbits[14:0], b_dat};
            if (c == 4114) begin
                ebit    = b_dat;
                done_at = b_done;
            end
            if (c == 4115) busy_after = b_busy;
            dones += int'(b_done);
            b_start = (c == 0);
            b_valid = 1'b1;
            b_din   = v;
        end
        b_valid = 1'b0;
        chk({tag, " start bit"}, 32'(sbit), 32'd0);
        chk({tag, " data ones"}, 32'(ones), (v == 8'hFF) ? 32'd4096 : 32'd0);
        chk({tag, " CRC after DATA"}, 32'(crc_at), 32'(ecrc));
        chk({tag, " CRC serial"}, 32'(crcbits), 32'(ecrc));
        chk({tag, " end bit"}, 32'(ebit), 32'd1);
        chk({tag, " DONE at 4114"}, 32'(done_at), 32'd1);
        chk({tag, " DONE count"}, 32'(dones), 32'd1);
        chk({tag, " idle after"}, 32'(busy_after), 32'd0);
    endtask

    initial begin
        vec_t        tv[$];
        logic [7:0]  fb [0:3];
        logic [15:0] crc;
        logic        bitv;
        int          dones;

        b_rst_n = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_din = 8'h00;
        s_rst_n = 1'b0; s_start = 1'b0; s_valid = 1'b0; s_din = 8'h00;
`ifdef SD_DAT_TX_ABORT_EN
        b_abort = 1'b0; s_abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset big", 32'({b_dat, b_oe, b_rdy, b_busy, b_done, b_err, b_crc}),
            32'({6'b100000, 16'h0000}));
        chk("reset small", 32'({s_dat, s_oe, s_rdy, s_busy, s_done, s_err, s_crc}),
            32'({6'b100000, 16'h0000}));
        b_rst_n = 1'b1;
        s_rst_n = 1'b1;

        // Reset asserted during byte 2 of a small frame
        @(negedge clk);
        s_start = 1'b1; s_valid = 1'b1; s_din = 8'h55;
        @(negedge clk);
        s_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midframe busy", 32'(s_busy), 32'd1);
        s_rst_n = 1'b0;
        #1;
        chk("async reset outputs", 32'({s_dat, s_oe, s_rdy, s_busy, s_done, s_err, s_crc}),
            32'({6'b100000, 16'h0000}));
        @(negedge clk);
        s_rst_n = 1'b1;
        s_valid = 1'b0;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            dones += int'(s_done) + int'(s_err) + int'(s_busy);
        end
        chk("no pulse after reset", 32'(dones), 32'd0);

        // Vector table: full small frame, ignored STARTs, restart, STRT underrun
        fb[0] = 8'hA5; fb[1] = 8'h3C; fb[2] = 8'h00; fb[3] = 8'hFF;
        crc = 16'h0000;
        tv.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        tv.push_back(mk(1'b0, fb[0], 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000));
        for (int j = 0; j < 32; j++) begin
            bitv = fb[j/8][7 - (j%8)];
            tv.push_back(mk(j == 8, (j/8 + 1 < 4) ? fb[j/8 + 1] : 8'hEE, 1'b1,
                            bitv, 1'b1, (j%8) == 0, 1'b1, 1'b0, 1'b0, crc));
            crc = crc_step(crc, bitv);
        end
        for (int i = 0; i < 16; i++)
            tv.push_back(mk(1'b0, 8'h00, 1'b0, crc[15 - i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, crc));
        tv.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, crc));
        tv.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, crc));
        tv.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000));
        tv.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000));
        tv.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        for (int k = 0; k < tv.size(); k++) begin
            @(negedge clk);
            chk($sformatf("vec %0d", k),
                32'({s_dat, s_oe, s_rdy, s_busy, s_done, s_err, s_crc}), 32'(tv[k].exp));
            s_start = tv[k].start;
            s_din   = tv[k].din;
            s_valid = tv[k].valid;
        end

        // Underrun: DIN_VALID dropped after bytes 0 and 1
        dones = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (c == 10) chk("underrun ready open", 32'(s_rdy), 32'd1);
            if (c == 17) chk("underrun pre", 32'({s_busy, s_err}), 32'b10);
            if (c == 18) chk("underrun ERR", 32'({s_err, s_oe, s_busy, s_dat}), 32'b1001);
            if (c == 19) chk("underrun ERR one cycle", 32'(s_err), 32'd0);
            dones += int'(s_done);
            s_start = (c == 0);
            s_valid = (c <= 2);
            s_din   = 8'(8'h10 + c);
        end
        chk("underrun no DONE", 32'(dones), 32'd0);

`ifdef SD_DAT_TX_ABORT_EN
        dones = 0;
        for (int c = 0; c < 56; c++) begin
            @(negedge clk);
            if (c == 36) chk("abort in CRCO", 32'(s_busy), 32'd1);
            if (c == 37) chk("abort ERR", 32'({s_err, s_oe, s_busy, s_dat}), 32'b1001);
            if (c == 38) chk("abort ERR one cycle", 32'(s_err), 32'd0);
            dones += int'(s_done);
            s_start = (c == 0);
            s_valid = 1'b1;
            s_din   = 8'h5A;
            s_abort = (c == 36);
        end
        s_valid = 1'b0;
        chk("abort no DONE", 32'(dones), 32'd0);
`endif

        run_big(8'hFF, 16'h7FA1, "ff512");
        run_big(8'h00, 16'h0000, "zero512");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
